// File: rtl/branch_resolve.sv
// ID-stage branch resolver: IF/ID register, BEQ/BNE/BLEZ/BGTZ evaluation, single delay slot,
// PC offset pre-adjustment and a saturating taken-branch counter.
module branch_resolve #(
    parameter logic [31:0] RESET_PC = 32'h00400020,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             control,
    output logic [15:0]      branch_offset,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic             range_err,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {StFill, StRun, StSlot} state_e;

    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpBlez = 6'b000110;
    localparam logic [5:0] OpBgtz = 6'b000111;

    state_e           state_q, state_d;
    logic [31:0]      id_instr_q, id_pc_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0]  op;
    logic [15:0] off;
    logic        cond;
    logic        off_wrap;
    logic        rs_le_zero;

    assign op         = id_instr_q[31:26];
    assign off        = id_instr_q[15:0];
    assign rs_le_zero = rs_data[31] | (rs_data == 32'd0);
    // off-1 wraps for the most negative offset, so the target cannot be reached
    assign off_wrap   = (off == 16'h8000);

    always_comb begin
        cond = 1'b0;
        case (op)
            OpBeq:   cond = (rs_data == rt_data);
            OpBne:   cond = (rs_data != rt_data);
            OpBlez:  cond = rs_le_zero;
            OpBgtz:  cond = ~rs_le_zero;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        control   = 1'b0;
        range_err = 1'b0;
        id_valid  = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            StFill: begin
                state_d = StRun;
            end
            StRun: begin
                id_valid  = 1'b1;
                range_err = cond & off_wrap;
                control   = cond & ~off_wrap;
                if (control) begin
                    state_d = StSlot;
                end
            end
            StSlot: begin
                // delay slot: any branch here is ignored
                id_valid = 1'b1;
                state_d  = StRun;
            end
            default: begin
                state_d = StFill;
            end
        endcase
        if (control && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFill;
            id_instr_q <= 32'd0;
            id_pc_q    <= RESET_PC;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= instr;
            id_pc_q    <= pc_in;
            cnt_q      <= cnt_d;
        end
    end

    // PC has already advanced one word, so compensate by one
    assign branch_offset = off - 16'd1;
    assign id_instr      = id_instr_q;
    assign id_pc         = id_pc_q;
    assign taken_count   = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a behavioural PC, instruction memory and register file.
module tb_branch_resolve;

    localparam logic [31:0] RESET_PC = 32'h00400020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_q;
    logic [31:0] instr, rs_data, rt_data;
    logic [31:0] imem [64];
    logic [31:0] rf [32];

    logic        control, id_valid, range_err;
    logic [15:0] branch_offset;
    logic [31:0] id_instr, id_pc;
    logic [15:0] taken_count;

    logic        control_s, id_valid_s, range_err_s;
    logic [15:0] branch_offset_s;
    logic [31:0] id_instr_s, id_pc_s;
    logic [2:0]  taken_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve #(.RESET_PC(RESET_PC), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .pc_in(pc_q), .instr(instr), .rs_data(rs_data),
        .rt_data(rt_data), .control(control), .branch_offset(branch_offset),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .range_err(range_err),
        .taken_count(taken_count)
    );

    // narrow counter copy so saturation is reachable in a short run
    branch_resolve #(.RESET_PC(RESET_PC), .CNT_W(3)) u_dut_sat (
        .clk(clk), .reset(reset), .pc_in(pc_q), .instr(instr), .rs_data(rs_data),
        .rt_data(rt_data), .control(control_s), .branch_offset(branch_offset_s),
        .id_instr(id_instr_s), .id_pc(id_pc_s), .id_valid(id_valid_s),
        .range_err(range_err_s), .taken_count(taken_count_s)
    );

    assign instr   = imem[pc_q[7:2]];
    assign rs_data = rf[id_instr[25:21]];
    assign rt_data = rf[id_instr[20:16]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else pc_q <= pc_q + 32'd4 +
                     (control ? {{14{branch_offset[15]}}, branch_offset, 2'b00} : 32'd0);
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] off);
        return {op, rs, rt, off};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    endtask

    task automatic start();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        clear_mem();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (id_instr !== 32'd0) begin errors++; $display("FAIL rst_id_instr got %h exp %h", id_instr, 32'd0); end
        checks++; if (id_pc !== RESET_PC) begin errors++; $display("FAIL rst_id_pc got %h exp %h", id_pc, RESET_PC); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL rst_control got %b exp 0", control); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL rst_range_err got %b exp 0", range_err); end
        checks++; if (taken_count !== 16'd0) begin errors++; $display("FAIL rst_taken got %h exp 0", taken_count); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fill_valid got %b exp 0", id_valid); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h00400020) begin errors++; $display("FAIL run_id_pc got %h exp %h", id_pc, 32'h00400020); end
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL nop_control got %b exp 0", control); end
        @(negedge clk);
        checks++; if (id_pc !== 32'h00400024) begin errors++; $display("FAIL run_id_pc2 got %h exp %h", id_pc, 32'h00400024); end
    endtask

    task automatic test_beq();
        clear_mem();
        imem[12] = enc(6'b000100, 5'd1, 5'd2, 16'd3);
        rf[1] = 32'd5;
        rf[2] = 32'd5;
        start();
        edges(5);
        checks++; if (id_pc !== 32'h00400030) begin errors++; $display("FAIL beq_id_pc got %h exp %h", id_pc, 32'h00400030); end
        checks++; if (control !== 1'b1) begin errors++; $display("FAIL beq_control got %b exp 1", control); end
        checks++; if (branch_offset !== 16'h0002) begin errors++; $display("FAIL beq_offset got %h exp 0002", branch_offset); end
        checks++; if (taken_count !== 16'd0) begin errors++; $display("FAIL beq_taken0 got %h exp 0", taken_count); end
        edges(1);
        checks++; if (pc_q !== 32'h00400040) begin errors++; $display("FAIL beq_target got %h exp %h", pc_q, 32'h00400040); end
        checks++; if (taken_count !== 16'd1) begin errors++; $display("FAIL beq_taken1 got %h exp 1", taken_count); end
        checks++; if (id_pc !== 32'h00400034) begin errors++; $display("FAIL beq_slot_pc got %h exp %h", id_pc, 32'h00400034); end
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL beq_slot_control got %b exp 0", control); end
    endtask

    task automatic test_bne();
        clear_mem();
        imem[8] = enc(6'b000101, 5'd1, 5'd2, 16'hFFFE);
        rf[1] = 32'd1;
        rf[2] = 32'd2;
        start();
        edges(1);
        checks++; if (control !== 1'b1) begin errors++; $display("FAIL bne_control got %b exp 1", control); end
        checks++; if (branch_offset !== 16'hFFFD) begin errors++; $display("FAIL bne_offset got %h exp FFFD", branch_offset); end
        edges(1);
        checks++; if (pc_q !== 32'h0040001C) begin errors++; $display("FAIL bne_target got %h exp %h", pc_q, 32'h0040001C); end
        rf[2] = 32'd1;
        start();
        edges(1);
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL bne_eq_control got %b exp 0", control); end
        edges(1);
        checks++; if (pc_q !== 32'h00400028) begin errors++; $display("FAIL bne_eq_pc got %h exp %h", pc_q, 32'h00400028); end
    endtask

    task automatic test_blez_bgtz();
        logic [31:0] vals [6];
        logic        exp_ctl [6];
        logic [5:0]  ops [6];
        vals    = '{32'd0, 32'h80000000, 32'd1, 32'd0, 32'h80000000, 32'd1};
        ops     = '{6'b000110, 6'b000110, 6'b000110, 6'b000111, 6'b000111, 6'b000111};
        exp_ctl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            clear_mem();
            imem[8] = enc(ops[i], 5'd1, 5'd0, 16'd5);
            rf[1] = vals[i];
            start();
            edges(1);
            checks++; if (control !== exp_ctl[i]) begin errors++; $display("FAIL blez_bgtz[%0d] control got %b exp %b", i, control, exp_ctl[i]); end
            checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL blez_bgtz[%0d] range_err got %b exp 0", i, range_err); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        imem[8]  = enc(6'b000100, 5'd1, 5'd2, 16'd4);
        imem[9]  = enc(6'b000100, 5'd1, 5'd2, 16'h8000);
        imem[13] = enc(6'b000100, 5'd1, 5'd2, 16'd1);
        rf[1] = 32'd7;
        rf[2] = 32'd7;
        start();
        edges(1);
        checks++; if (control !== 1'b1) begin errors++; $display("FAIL b2b_first got %b exp 1", control); end
        edges(1);
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL b2b_slot_control got %b exp 0", control); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL b2b_slot_range got %b exp 0", range_err); end
        checks++; if (id_pc !== 32'h00400024) begin errors++; $display("FAIL b2b_slot_pc got %h exp %h", id_pc, 32'h00400024); end
        checks++; if (pc_q !== 32'h00400034) begin errors++; $display("FAIL b2b_target got %h exp %h", pc_q, 32'h00400034); end
        checks++; if (taken_count !== 16'd1) begin errors++; $display("FAIL b2b_taken1 got %h exp 1", taken_count); end
        edges(1);
        checks++; if (id_pc !== 32'h00400034) begin errors++; $display("FAIL b2b_third_pc got %h exp %h", id_pc, 32'h00400034); end
        checks++; if (control !== 1'b1) begin errors++; $display("FAIL b2b_third got %b exp 1", control); end
        checks++; if (branch_offset !== 16'h0000) begin errors++; $display("FAIL b2b_third_off got %h exp 0000", branch_offset); end
        edges(1);
        checks++; if (pc_q !== 32'h0040003C) begin errors++; $display("FAIL b2b_target2 got %h exp %h", pc_q, 32'h0040003C); end
        checks++; if (taken_count !== 16'd2) begin errors++; $display("FAIL b2b_taken2 got %h exp 2", taken_count); end
    endtask

    task automatic test_range();
        clear_mem();
        imem[8] = enc(6'b000100, 5'd1, 5'd2, 16'h8000);
        imem[9] = enc(6'b000100, 5'd1, 5'd2, 16'h8000);
        rf[1] = 32'd3;
        rf[2] = 32'd3;
        start();
        edges(1);
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", range_err); end
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL range_control got %b exp 0", control); end
        checks++; if (branch_offset !== 16'h7FFF) begin errors++; $display("FAIL range_offset got %h exp 7FFF", branch_offset); end
        edges(1);
        checks++; if (id_pc !== 32'h00400024) begin errors++; $display("FAIL range_next_pc got %h exp %h", id_pc, 32'h00400024); end
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_err2 got %b exp 1", range_err); end
        checks++; if (taken_count !== 16'd0) begin errors++; $display("FAIL range_taken got %h exp 0", taken_count); end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        imem[8] = enc(6'b000100, 5'd1, 5'd2, 16'd4);
        rf[1] = 32'd1;
        rf[2] = 32'd1;
        start();
        edges(1);
        checks++; if (control !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", control); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL mid_control got %b exp 0", control); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", id_valid); end
        checks++; if (taken_count !== 16'd0) begin errors++; $display("FAIL mid_taken got %h exp 0", taken_count); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (control !== 1'b0) begin errors++; $display("FAIL mid_fill_control got %b exp 0", control); end
        @(negedge clk);
        checks++; if (control !== 1'b1) begin errors++; $display("FAIL mid_rerun got %b exp 1", control); end
    endtask

    task automatic test_saturate();
        clear_mem();
        // branch to itself: taken every other cycle
        imem[8] = enc(6'b000100, 5'd1, 5'd2, 16'hFFFF);
        rf[1] = 32'd9;
        rf[2] = 32'd9;
        start();
        edges(12);
        checks++; if (taken_count_s !== 3'd6) begin errors++; $display("FAIL sat_6 got %0d exp 6", taken_count_s); end
        checks++; if (taken_count !== 16'd6) begin errors++; $display("FAIL cnt_6 got %0d exp 6", taken_count); end
        edges(2);
        checks++; if (taken_count_s !== 3'd7) begin errors++; $display("FAIL sat_7 got %0d exp 7", taken_count_s); end
        edges(6);
        checks++; if (taken_count_s !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", taken_count_s); end
        checks++; if (taken_count !== 16'd10) begin errors++; $display("FAIL cnt_10 got %0d exp 10", taken_count); end
        checks++; if (pc_q !== 32'h00400020) begin errors++; $display("FAIL sat_loop_pc got %h exp %h", pc_q, 32'h00400020); end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_bne();
        test_blez_bgtz();
        test_back_to_back();
        test_range();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
